cla4_serial_adder_ctrl: RTL and testbench
=========================================

Name: cla4_serial_adder_ctrl

Overview:
- Sequencing controller that reuses one existing `cla4` (4-bit carry-lookahead adder; ports a, b, ci, s, co) to add two NIBBLES×4-bit operands one nibble per clock, least significant nibble first.
- Carry is chained between nibbles through a carry register.
- Uses a start/busy/done handshake and registered result outputs.
- This is the team's area-reduced wide adder: one 4-bit CLA replaces NIBBLES parallel instances.

Parameters:
- NIBBLES, 8, number of 4-bit nibbles; operand width W = 4×NIBBLES (default 32). Legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  W  operand A; captured on the accepting edge.
- b  input  W  operand B; captured on the accepting edge.
- ci  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; s and co are valid from this cycle on.
- s  output  W  registered sum; holds until the next completion.
- co  output  1  registered carry-out of the most significant nibble.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - state = IDLE; busy = 0, done = 0, s = 0, co = 0.
  - Count, carry register and operand/sum shift registers all cleared.
  - Any in-flight operation is discarded; no done is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start = 1 at edge E0: load a_sh = a, b_sh = b, c_reg = ci, cnt = 0 -> RUN. With start = 0, stay in IDLE.
  - RUN, each edge:
    - The `cla4` operands are a_sh[3:0], b_sh[3:0] and c_reg.
    - sum_sh <= {cla4.s, sum_sh[W-1:4]}; a_sh and b_sh shift right by 4; c_reg <= cla4.co; cnt <= cnt + 1.
    - The edge where cnt = NIBBLES-1 is EN. At EN: s <= the next sum_sh value; co <= cla4.co; -> DONE.
  - DONE: done = 1 for exactly this one cycle; next edge -> IDLE.
- Latency and throughput:
  - done is high in the cycle following edge EN, where EN = E0 + NIBBLES edges.
  - Default: done asserts 8 cycles after the start edge.
  - Next start is accepted at the first edge in IDLE. Back-to-back throughput is one operation per NIBBLES + 2 cycles.
- start while busy (RUN or DONE) is ignored and not queued. a, b and ci may change freely after E0 with no effect on the result.
- s and co change only at EN. During RUN they hold the previous result.
- Arithmetic is unsigned modulo 2^W. {co, s} equals a + b + ci exactly (W+1 bits).
- cnt width is max(1, clog2(NIBBLES)).
- NIBBLES = 1: a single RUN cycle; behaviour equals one registered `cla4` add.
- done is decoded from state (state == DONE) and is glitch-free registered state.
- No X may propagate to outputs after reset deassertion.

Decomposition:
- Shared package/include holds:
  - State encoding localparams: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - Default NIBBLES.
- One sub-module: the existing `cla4`, instantiated unmodified as `U0_cla4`.
- FSM, counter, carry register and shift registers all live in this module; no further sub-modules.

Test Plan:
- Reset with start = 1 held: busy = 0, done = 0, s = 0, co = 0. Release reset, pulse start with a = 0, b = 0, ci = 0 -> done 8 cycles later, s = 0x00000000, co = 0.
- a = 0x12345678, b = 0x11111111, ci = 0 -> s = 0x23456789, co = 0. done is a single-cycle pulse, and busy stays high from E0 through the DONE cycle.
- a = 0xFFFFFFFF, b = 0x00000000, ci = 1 -> s = 0x00000000, co = 1. Checks the carry ripple through all 8 nibbles. Then a = 0xFFFFFFFF, b = 0xFFFFFFFF, ci = 1 -> s = 0xFFFFFFFF, co = 1.
- Start 0x00000005 + 0x00000004. During RUN, pulse start with 0xFFFFFFFF + 0x1 and change a/b -> ignored; result s = 0x00000009, co = 0; no second done.
- Start 0xFFFFFFFF + 0x1. Assert reset asynchronously mid-cycle at RUN cycle 4 -> outputs 0 immediately, no done. After release, 0x00000001 + 0x00000001 -> s = 0x00000002.
- Random regression: 1000 random a, b, ci with start re-asserted at the first IDLE edge -> {co, s} == a + b + ci every time. Repeat with NIBBLES = 1 (4-bit, done 1 cycle after start) and NIBBLES = 16 (64-bit).

Source files
------------

// File: rtl/cla4_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial wide adder controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cla4_serial_adder_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t RUN  = 2'b01;
  localparam state_t DONE = 2'b10;

  // Default operand width is 8 nibbles (32 bits).
  localparam int NIBBLES_DEF = 8;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder: s = a + b + ci, co = carry out.
// Latency: purely combinational.
// Backpressure: none.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is computed directly from generate/propagate terms, no ripple.
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign co     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s = w_p ^ w_c;

endmodule

// File: rtl/cla4_serial_adder_ctrl.sv
// Wide unsigned adder that reuses one cla4, one nibble per clock, LS nibble first.
// Latency: done is high in the cycle after start edge + NIBBLES edges.
// Backpressure: start is only sampled in IDLE; start while busy is dropped, not queued.
module cla4_serial_adder_ctrl
  import cla4_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ci,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   co
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_a_sh;
  logic [W-1:0]    r_b_sh;
  logic [W-1:0]    r_sum_sh;
  logic            r_c;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_s;
  logic            r_co;

  logic [3:0]      w_nib_s;
  logic            w_nib_co;
  logic            w_last;
  logic [W-1:0]    w_sum_sh_nxt;
  logic [W-1:0]    w_a_sh_nxt;
  logic [W-1:0]    w_b_sh_nxt;

  cla4 U0_cla4 (
    .a  (r_a_sh[3:0]),
    .b  (r_b_sh[3:0]),
    .ci (r_c),
    .s  (w_nib_s),
    .co (w_nib_co)
  );

  // New nibble enters at the top; after NIBBLES shifts the register holds the full sum.
  // Written as a shift of the concatenation so the NIBBLES == 1 case needs no special branch.
  assign w_sum_sh_nxt = W'({w_nib_s, r_sum_sh} >> 4);
  assign w_a_sh_nxt   = r_a_sh >> 4;
  assign w_b_sh_nxt   = r_b_sh >> 4;
  assign w_last       = (r_state == RUN) && (r_cnt == LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on last nibble, DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded straight from the state register, so done is a clean one-cycle pulse.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: capture operands on accept, shift one nibble per RUN cycle, publish at the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_s      <= '0;
      r_co     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_c    <= ci;
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= w_a_sh_nxt;
          r_b_sh   <= w_b_sh_nxt;
          r_sum_sh <= w_sum_sh_nxt;
          r_c      <= w_nib_co;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_s  <= w_sum_sh_nxt;
            r_co <= w_nib_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign s  = r_s;
  assign co = r_co;

endmodule

// File: tb/tb_cla4_serial_adder_ctrl.sv
// Self-checking bench: directed cases plus random regression at 1, 8 and 16 nibbles.
// Reference is plain wide arithmetic: {co, s} == a + b + ci over 4*NIBBLES bits.
// Start is re-issued on the first IDLE edge after each completion.
module tb_cla4_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st1, st8, st16;
  logic [3:0]  a1, b1;
  logic [31:0] a8, b8;
  logic [63:0] a16, b16;
  logic        ci1, ci8, ci16;
  logic        busy1, busy8, busy16;
  logic        done1, done8, done16;
  logic [3:0]  s1;
  logic [31:0] s8;
  logic [63:0] s16;
  logic        co1, co8, co16;

  int n_vec = 0;
  int n_err = 0;

  cla4_serial_adder_ctrl #(.NIBBLES(8)) u_dut8 (
    .clk(clk), .reset(rst), .start(st8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .s(s8), .co(co8)
  );

  cla4_serial_adder_ctrl #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .reset(rst), .start(st1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .s(s1), .co(co1)
  );

  cla4_serial_adder_ctrl #(.NIBBLES(16)) u_dut16 (
    .clk(clk), .reset(rst), .start(st16), .a(a16), .b(b16), .ci(ci16),
    .busy(busy16), .done(done16), .s(s16), .co(co16)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum of the low 4*n bits of each operand plus carry-in.
  function automatic logic [64:0] model(input int n, input logic [63:0] av,
                                        input logic [63:0] bv, input logic cv);
    logic [64:0] m;
    m = (65'd1 << (4 * n)) - 65'd1;
    return ({1'b0, av} & m) + ({1'b0, bv} & m) + {64'd0, cv};
  endfunction

  task automatic drive(input int n, input logic stv, input logic [63:0] av,
                       input logic [63:0] bv, input logic cv);
    case (n)
      1: begin st1 = stv; a1 = av[3:0]; b1 = bv[3:0]; ci1 = cv; end
      8: begin st8 = stv; a8 = av[31:0]; b8 = bv[31:0]; ci8 = cv; end
      default: begin st16 = stv; a16 = av; b16 = bv; ci16 = cv; end
    endcase
  endtask

  function automatic logic get_done(input int n);
    case (n)
      1: return done1;
      8: return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic get_busy(input int n);
    case (n)
      1: return busy1;
      8: return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [64:0] get_res(input int n);
    case (n)
      1: return {60'd0, co1, s1};
      8: return {32'd0, co8, s8};
      default: return {co16, s16};
    endcase
  endfunction

  // Called just after a negedge with the DUT in IDLE; returns at a negedge with it back in IDLE.
  task automatic run_op(input int n, input logic [63:0] av, input logic [63:0] bv,
                        input logic cv, input string tag, output logic [64:0] res);
    int k;
    drive(n, 1'b1, av, bv, cv);
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs after the accepting edge; the result must not care.
    drive(n, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    chk({tag, " busy"}, {64'd0, get_busy(n)}, 65'd1);
    k = 0;
    while (!get_done(n) && k < 64) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 65'(k), 65'(n));
    res = get_res(n);
    @(negedge clk);
    chk({tag, " done/busy after"}, {63'd0, get_done(n), get_busy(n)}, 65'd0);
  endtask

  initial begin
    logic [64:0] res;
    logic [63:0] ra, rb;
    logic        rc;
    int          k;
    int          ndone;

    rst = 1'b0;
    drive(1, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(16, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(8, 1'b1, 64'd0, 64'd0, 1'b0);
    #1 rst = 1'b1;

    // Reset with start held high.
    repeat (2) @(negedge clk);
    chk("reset busy", {64'd0, busy8}, 65'd0);
    chk("reset done", {64'd0, done8}, 65'd0);
    chk("reset res8", get_res(8), 65'd0);
    chk("reset res1", get_res(1), 65'd0);
    chk("reset res16", get_res(16), 65'd0);
    @(negedge clk);
    chk("reset start ignored", {64'd0, busy8}, 65'd0);
    rst = 1'b0;
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);

    // Directed 32-bit cases.
    run_op(8, 64'h0, 64'h0, 1'b0, "zero", res);
    chk("zero res", res, 65'h0);
    run_op(8, 64'h12345678, 64'h11111111, 1'b0, "mix", res);
    chk("mix res", res, 65'h0_23456789);
    run_op(8, 64'hFFFFFFFF, 64'h0, 1'b1, "ripple", res);
    chk("ripple res", res, 65'h1_00000000);
    run_op(8, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, "allones", res);
    chk("allones res", res, 65'h1_FFFFFFFF);

    // Start pulsed during RUN must be ignored.
    drive(8, 1'b1, 64'h5, 64'h4, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 64'h77, 64'h66, 1'b1);
    @(negedge clk);
    drive(8, 1'b1, 64'hFFFFFFFF, 64'h1, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 64'hABCDEF01, 64'h12345678, 1'b1);
    k = 0;
    while (!done8 && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("busy-start done seen", {64'd0, done8}, 65'd1);
    chk("busy-start res", get_res(8), 65'h0_00000009);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("busy-start no 2nd done", 65'(ndone), 65'd0);

    // Asynchronous reset mid-run; previous result must hold during RUN until then.
    drive(8, 1'b1, 64'hFFFFFFFF, 64'h1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 64'h0, 64'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold during run", get_res(8), 65'h0_00000009);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", {64'd0, busy8}, 65'd0);
    chk("async rst done", {64'd0, done8}, 65'd0);
    chk("async rst res", get_res(8), 65'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("no done after reset", 65'(ndone), 65'd0);
    run_op(8, 64'h1, 64'h1, 1'b0, "post-reset", res);
    chk("post-reset res", res, 65'h0_00000002);

    // Random regression at each width.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      run_op(8, ra, rb, rc, "rnd8", res);
      chk($sformatf("rnd8 #%0d res", i), res, model(8, ra, rb, rc));
    end
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      run_op(1, ra, rb, rc, "rnd1", res);
      chk($sformatf("rnd1 #%0d res", i), res, model(1, ra, rb, rc));
    end
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      run_op(16, ra, rb, rc, "rnd16", res);
      chk($sformatf("rnd16 #%0d res", i), res, model(16, ra, rb, rc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
